// File: rtl/pll_lmmi_pkg.sv
// ----------------------------------------------------------------------------
// pll_lmmi_pkg
// Shared definitions for the PLL LMMI initiator:
//   - command opcode encodings carried on cmd_op
//   - FSM state enumeration used by pll_lmmi_initiator
//   - PLL_CORE register offsets used by the clock-management controller
// ----------------------------------------------------------------------------
package pll_lmmi_pkg;

   // Command opcodes (2'b11 is reserved and answered with an error).
   localparam logic [1:0] OP_WR  = 2'b00;
   localparam logic [1:0] OP_RD  = 2'b01;
   localparam logic [1:0] OP_RMW = 2'b10;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ_RD  = 3'd1,
      WAIT_RD = 3'd2,
      REQ_WR  = 3'd3,
      RESP    = 3'd4
   } lmmi_state_e;

   // PLL_CORE dynamic-configuration register offsets used by the controller.
   localparam logic [6:0] PLL_REG_DIVA  = 7'h12;
   localparam logic [6:0] PLL_REG_DIVB  = 7'h13;
   localparam logic [6:0] PLL_REG_FBK   = 7'h05;
   localparam logic [6:0] PLL_REG_PHASE = 7'h20;

endpackage

// File: rtl/lmmi_timeout_ctr.sv
// ----------------------------------------------------------------------------
// lmmi_timeout_ctr
// Bounded wait counter for the LMMI initiator. Counts the cycles spent in a
// waiting state and flags the cycle in which the wait reaches TIMEOUT cycles.
// Ports:
//   clk       in  clock
//   rst       in  asynchronous active-high reset
//   clr_i     in  restart the count (takes priority over en_i)
//   en_i      in  a waiting state is active this cycle
//   expired_o out this is the TIMEOUT-th consecutive waiting cycle
// ----------------------------------------------------------------------------
module lmmi_timeout_ctr #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != CNT_W'(TIMEOUT))) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // cnt_q counts the cycles already waited, so the current cycle is number
   // cnt_q+1; the wait has reached TIMEOUT when that equals TIMEOUT.
   assign expired_o = en_i && (cnt_q >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/pll_lmmi_initiator.sv
// ----------------------------------------------------------------------------
// pll_lmmi_initiator
// Drives the PLL_CORE LMMI dynamic-configuration port on behalf of fabric
// logic. One command (write / read / masked read-modify-write) is accepted at
// a time and answered with exactly one response pulse.
// Ports:
//   clk, rst                 clock (also LMMICLK), async active-high reset
//   cmd_valid/cmd_ready      command handshake; ready only while idle
//   cmd_op/offset/wdata/mask command fields, captured on acceptance
//   rsp_valid/rdata/err      one-cycle response; rdata held until next one
//   lmmi_request/wr_rdn/offset/wdata   registered LMMI request outputs
//   lmmi_ready/rdata/rdata_valid       LMMI responder inputs
//   busy                     FSM not in IDLE
// ----------------------------------------------------------------------------
module pll_lmmi_initiator
   import pll_lmmi_pkg::*;
#(
   parameter int OFFSET_W = 7,
   parameter int DATA_W   = 8,
   parameter int TIMEOUT  = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_op,
   input  logic [OFFSET_W-1:0] cmd_offset,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W-1:0]   cmd_mask,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                lmmi_request,
   output logic                lmmi_wr_rdn,
   output logic [OFFSET_W-1:0] lmmi_offset,
   output logic [DATA_W-1:0]   lmmi_wdata,
   input  logic                lmmi_ready,
   input  logic [DATA_W-1:0]   lmmi_rdata,
   input  logic                lmmi_rdata_valid,
   output logic                busy
);

   function automatic logic [DATA_W-1:0] rmw_merge(input logic [DATA_W-1:0] old_v,
                                                   input logic [DATA_W-1:0] new_v,
                                                   input logic [DATA_W-1:0] mask_v);
      return (old_v & ~mask_v) | (new_v & mask_v);
   endfunction

   lmmi_state_e         state_q, state_d;
   logic [1:0]          op_q, op_d;
   logic [OFFSET_W-1:0] offs_q, offs_d;
   logic [DATA_W-1:0]   mask_q, mask_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic                lreq_q, lreq_d;
   logic                lwr_q, lwr_d;
   logic [DATA_W-1:0]   lwdata_q, lwdata_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

   logic                to_clr, to_en, to_expired;

   // Restart the wait count on every state change; count while waiting.
   assign to_clr = (state_d != state_q);
   assign to_en  = (state_q == REQ_RD) || (state_q == WAIT_RD) || (state_q == REQ_WR);

   lmmi_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (to_clr),
      .en_i      (to_en),
      .expired_o (to_expired)
   );

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      offs_d      = offs_q;
      mask_d      = mask_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      lreq_d      = lreq_q;
      lwr_d       = lwr_q;
      lwdata_d    = lwdata_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;

      unique case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               op_d     = cmd_op;
               offs_d   = cmd_offset;
               mask_d   = cmd_mask;
               lwdata_d = cmd_wdata;
               rdata_d  = '0;
               err_d    = 1'b0;
               if (cmd_op == OP_WR) begin
                  state_d = REQ_WR;
                  lreq_d  = 1'b1;
                  lwr_d   = 1'b1;
               end else if ((cmd_op == OP_RD) || (cmd_op == OP_RMW)) begin
                  state_d = REQ_RD;
                  lreq_d  = 1'b1;
                  lwr_d   = 1'b0;
               end else begin
                  // Reserved opcode: answer with an error, no bus activity.
                  state_d = RESP;
                  err_d   = 1'b1;
               end
            end
         end
         REQ_RD: begin
            if (lmmi_ready) begin
               state_d = WAIT_RD;
               lreq_d  = 1'b0;
            end else if (to_expired) begin
               state_d = RESP;
               lreq_d  = 1'b0;
               err_d   = 1'b1;
            end
         end
         WAIT_RD: begin
            if (lmmi_rdata_valid) begin
               rdata_d = lmmi_rdata;
               if (op_q == OP_RMW) begin
                  // lwdata_q still holds the command write data here.
                  state_d  = REQ_WR;
                  lreq_d   = 1'b1;
                  lwr_d    = 1'b1;
                  lwdata_d = rmw_merge(lmmi_rdata, lwdata_q, mask_q);
               end else begin
                  state_d = RESP;
               end
            end else if (to_expired) begin
               state_d = RESP;
               err_d   = 1'b1;
            end
         end
         REQ_WR: begin
            if (lmmi_ready) begin
               state_d = RESP;
               lreq_d  = 1'b0;
            end else if (to_expired) begin
               state_d = RESP;
               lreq_d  = 1'b0;
               err_d   = 1'b1;
            end
         end
         RESP: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = err_q;
            rsp_rdata_d = err_q ? '0 : rdata_q;
         end
         default: begin
            state_d = IDLE;
            lreq_d  = 1'b0;
         end
      endcase

      // Registered ready: low in reset and for every non-idle cycle.
      cmd_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= '0;
         offs_q      <= '0;
         mask_q      <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         lreq_q      <= 1'b0;
         lwr_q       <= 1'b0;
         lwdata_q    <= '0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         offs_q      <= offs_d;
         mask_q      <= mask_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         lreq_q      <= lreq_d;
         lwr_q       <= lwr_d;
         lwdata_q    <= lwdata_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_err      = rsp_err_q;
   assign rsp_rdata    = rsp_rdata_q;
   assign lmmi_request = lreq_q;
   assign lmmi_wr_rdn  = lwr_q;
   assign lmmi_offset  = offs_q;
   assign lmmi_wdata   = lwdata_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_pll_lmmi_initiator.sv
module tb_pll_lmmi_initiator;

   localparam int NEVER = 1000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [6:0] cmd_offset = '0;
   logic [7:0] cmd_wdata = '0;
   logic [7:0] cmd_mask = '0;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       lmmi_request;
   logic       lmmi_wr_rdn;
   logic [6:0] lmmi_offset;
   logic [7:0] lmmi_wdata;
   logic       lmmi_ready = 1'b0;
   logic [7:0] lmmi_rdata = 8'hEE;
   logic       lmmi_rdata_valid = 1'b0;
   logic       busy;

   int tests = 0;
   int fails = 0;

   pll_lmmi_initiator #(.OFFSET_W(7), .DATA_W(8), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_offset(cmd_offset), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .lmmi_request(lmmi_request), .lmmi_wr_rdn(lmmi_wr_rdn),
      .lmmi_offset(lmmi_offset), .lmmi_wdata(lmmi_wdata),
      .lmmi_ready(lmmi_ready), .lmmi_rdata(lmmi_rdata),
      .lmmi_rdata_valid(lmmi_rdata_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   // ---------------- LMMI responder model (driven on the falling edge) -----
   int         rdy_dly = 0;          // request cycles before ready (NEVER = none)
   int         rdv_dly = 1;          // cycles from ready to rdata_valid (0 = none)
   logic [7:0] mem [128];
   bit         mem_init = 1'b0;
   int         req_cnt = 0;
   int         req_cycles = 0;
   int         wr_hs = 0;
   int         rd_hs = 0;
   int         unstable = 0;
   int         rd_left = 0;
   logic [7:0] rd_val = '0;
   logic [7:0] last_wdata = '0;
   logic [6:0] last_off = '0;
   logic [6:0] prev_off = '0;
   logic [7:0] prev_wd = '0;
   logic       prev_wr = 1'b0;

   always @(negedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 128; i++) mem[i] = 8'h00;
         mem[7'h05] = 8'h3C;
         mem[7'h20] = 8'hB9;
         mem_init = 1'b1;
      end
      lmmi_rdata_valid = 1'b0;
      lmmi_rdata       = 8'hEE;
      if (rd_left > 0) begin
         rd_left--;
         if (rd_left == 0) begin
            lmmi_rdata_valid = 1'b1;
            lmmi_rdata       = rd_val;
         end
      end
      if (lmmi_request) begin
         req_cycles++;
         if (req_cnt > 0 && (lmmi_offset !== prev_off || lmmi_wdata !== prev_wd ||
                             lmmi_wr_rdn !== prev_wr))
            unstable++;
         prev_off = lmmi_offset;
         prev_wd  = lmmi_wdata;
         prev_wr  = lmmi_wr_rdn;
         if (req_cnt == rdy_dly) begin
            lmmi_ready = 1'b1;
            last_off   = lmmi_offset;
            if (lmmi_wr_rdn) begin
               wr_hs++;
               mem[lmmi_offset] = lmmi_wdata;
               last_wdata = lmmi_wdata;
            end else begin
               rd_hs++;
               rd_val  = mem[lmmi_offset];
               rd_left = rdv_dly;
            end
         end else begin
            lmmi_ready = 1'b0;
         end
         req_cnt++;
      end else begin
         lmmi_ready = 1'b0;
         req_cnt    = 0;
      end
   end

   // ---------------- checking helpers ---------------------------------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      string      name;
      logic [1:0] op;
      logic [6:0] off;
      logic [7:0] wd;
      logic [7:0] mask;
      int         rdy;
      int         rdv;
      logic       exp_err;
      logic [7:0] exp_rdata;
      int         exp_wr;
      int         exp_rd;
      logic [7:0] exp_wdata;
      int         exp_req;
      int         exp_lat;
   } vec_t;

   task automatic apply(input vec_t v);
      int n, got, bad_busy, wr0, rd0, rq0, us0, waitc;
      logic       e;
      logic [7:0] d;
      rdy_dly = v.rdy;
      rdv_dly = v.rdv;
      wr0 = wr_hs; rd0 = rd_hs; rq0 = req_cycles; us0 = unstable;
      @(negedge clk);
      waitc = 0;
      while (!cmd_ready && waitc < 10) begin
         @(negedge clk);
         waitc++;
      end
      chk({v.name, " cmd_ready idle"}, 32'(cmd_ready), 32'd1);
      cmd_op = v.op; cmd_offset = v.off; cmd_wdata = v.wd; cmd_mask = v.mask;
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid  = 1'b0;
      // Changing the inputs after acceptance must not affect the transaction.
      cmd_op     = ~v.op;
      cmd_offset = ~v.off;
      cmd_wdata  = ~v.wd;
      cmd_mask   = ~v.mask;
      n = 1; got = 0; bad_busy = 0;
      e = 1'b0; d = '0;
      while (n < 100) begin
         if (rsp_valid) begin
            got = 1;
            e = rsp_err;
            d = rsp_rdata;
            break;
         end
         if (!busy || cmd_ready) bad_busy++;
         @(negedge clk);
         n++;
      end
      chk({v.name, " rsp seen"}, 32'(got), 32'd1);
      chk({v.name, " latency"}, 32'(n), 32'(v.exp_lat));
      chk({v.name, " rsp_err"}, 32'(e), 32'(v.exp_err));
      if (v.op != 2'b00) chk({v.name, " rsp_rdata"}, 32'(d), 32'(v.exp_rdata));
      chk({v.name, " write count"}, 32'(wr_hs - wr0), 32'(v.exp_wr));
      chk({v.name, " read count"}, 32'(rd_hs - rd0), 32'(v.exp_rd));
      if (v.exp_wr != 0) begin
         chk({v.name, " write data"}, 32'(last_wdata), 32'(v.exp_wdata));
         chk({v.name, " write offset"}, 32'(last_off), 32'(v.off));
      end
      chk({v.name, " request cycles"}, 32'(req_cycles - rq0), 32'(v.exp_req));
      chk({v.name, " request stable"}, 32'(unstable - us0), 32'd0);
      chk({v.name, " busy during txn"}, 32'(bad_busy), 32'd0);
      @(negedge clk);
      chk({v.name, " rsp one pulse"}, 32'(rsp_valid), 32'd0);
      chk({v.name, " rdata held"}, 32'(rsp_rdata), 32'(d));
   endtask

   vec_t vecs [10];

   initial begin
      int n, cnt, accepts, bad, rq0;

      vecs[0] = '{"wr12", 2'b00, 7'h12, 8'hA5, 8'h00, 2,     1, 1'b0, 8'h00, 1, 0, 8'hA5, 3,  5};
      vecs[1] = '{"rd05", 2'b01, 7'h05, 8'h00, 8'h00, 0,     4, 1'b0, 8'h3C, 0, 1, 8'h00, 1,  7};
      vecs[2] = '{"rmw20", 2'b10, 7'h20, 8'h07, 8'h0F, 0,    1, 1'b0, 8'hB9, 1, 1, 8'hB7, 2,  5};
      vecs[3] = '{"wr7f", 2'b00, 7'h7F, 8'h5A, 8'h00, 0,     1, 1'b0, 8'h00, 1, 0, 8'h5A, 1,  3};
      vecs[4] = '{"wr_tmo", 2'b00, 7'h01, 8'h11, 8'h00, NEVER, 1, 1'b1, 8'h00, 0, 0, 8'h00, 16, 18};
      vecs[5] = '{"rd_tmo", 2'b01, 7'h05, 8'h00, 8'h00, 0,   0, 1'b1, 8'h00, 0, 1, 8'h00, 1,  19};
      vecs[6] = '{"rd20", 2'b01, 7'h20, 8'h00, 8'h00, 1,     1, 1'b0, 8'hB7, 0, 1, 8'h00, 2,  5};
      vecs[7] = '{"resv", 2'b11, 7'h33, 8'h44, 8'h00, 0,     1, 1'b1, 8'h00, 0, 0, 8'h00, 0,  2};
      vecs[8] = '{"rmw_all", 2'b10, 7'h12, 8'h00, 8'hFF, 1,  2, 1'b0, 8'hA5, 1, 1, 8'h00, 4,  8};
      vecs[9] = '{"rmw_none", 2'b10, 7'h7F, 8'hFF, 8'h00, 0, 1, 1'b0, 8'h5A, 1, 1, 8'h5A, 2,  5};

      // Reset state.
      repeat (3) @(negedge clk);
      chk("reset cmd_ready", 32'(cmd_ready), 32'd0);
      chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset rsp_err", 32'(rsp_err), 32'd0);
      chk("reset rsp_rdata", 32'(rsp_rdata), 32'd0);
      chk("reset lmmi_request", 32'(lmmi_request), 32'd0);
      chk("reset lmmi_wr_rdn", 32'(lmmi_wr_rdn), 32'd0);
      chk("reset lmmi_offset", 32'(lmmi_offset), 32'd0);
      chk("reset lmmi_wdata", 32'(lmmi_wdata), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("cmd_ready after reset", 32'(cmd_ready), 32'd1);

      for (int i = 0; i < 10; i++) apply(vecs[i]);

      // Reset while waiting for read data: everything stops at once.
      rdy_dly = 0; rdv_dly = 10;
      @(negedge clk);
      cmd_op = 2'b01; cmd_offset = 7'h05; cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);                // now in WAIT_RD
      chk("wait_rd busy before rst", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst lmmi_request", 32'(lmmi_request), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (rsp_valid || busy) cnt++;
      end
      chk("late rdata_valid no rsp", 32'(cnt), 32'd0);

      // Reset while a request is outstanding drops lmmi_request immediately.
      rdy_dly = NEVER;
      @(negedge clk);
      cmd_op = 2'b00; cmd_offset = 7'h09; cmd_wdata = 8'h77; cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("req high before rst", 32'(lmmi_request), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst drops request", 32'(lmmi_request), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      rdy_dly = 0;
      @(negedge clk);

      // Reserved op with cmd_valid held high through the transaction.
      rq0 = req_cycles;
      cmd_op = 2'b11; cmd_valid = 1'b1;
      n = 0; accepts = 0; bad = 0; cnt = 0;
      while (n < 20) begin
         if (rsp_valid) begin
            cnt = 1;
            cmd_valid = 1'b0;
            break;
         end
         if (cmd_valid && cmd_ready) accepts++;
         if (busy && cmd_ready) bad++;
         @(negedge clk);
         n++;
      end
      chk("held valid rsp seen", 32'(cnt), 32'd1);
      chk("held valid rsp cycle", 32'(n), 32'd2);
      chk("held valid rsp_err", 32'(rsp_err), 32'd1);
      chk("held valid accepted once", 32'(accepts), 32'd1);
      chk("held valid ready low busy", 32'(bad), 32'd0);
      chk("reserved no lmmi", 32'(req_cycles - rq0), 32'd0);

      // A normal command still works afterwards.
      apply(vecs[3]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: simulation did not finish, %0d checks so far", tests);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pll_lmmi_initiator.md
Name: pll_lmmi_initiator

Overview:
- LMMI initiator that drives the PLL_CORE dynamic-configuration port (the responder side is the hard PLL).
- Accepts single register commands from fabric logic: write, read, or masked read-modify-write (RMW) of one 8-bit PLL register, e.g. the DIVA field.
- Sequences the LMMI request/ready/rdata_valid handshake, bounds every wait with a timeout, and returns one response per command.
- Sits between the clock-management controller and the PLL_CORE LMMI pins.

Parameters:
- OFFSET_W, 7, LMMI register offset width.
- DATA_W, 8, LMMI data width.
- TIMEOUT, 255, max cycles waited for lmmi_ready or lmmi_rdata_valid; minimum 1.

Ports:
- clk  in  1  single clock; also drives the PLL LMMICLK.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  00 write, 01 read, 10 RMW, 11 reserved.
- cmd_offset  in  OFFSET_W  register offset.
- cmd_wdata  in  DATA_W  write data.
- cmd_mask  in  DATA_W  RMW bit mask; 1 = take the bit from cmd_wdata.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data (RMW: the value read before modification).
- rsp_err  out  1  timeout or reserved op; valid with rsp_valid.
- lmmi_request  out  1  LMMIREQUEST.
- lmmi_wr_rdn  out  1  LMMIWRRD_N; 1 = write.
- lmmi_offset  out  OFFSET_W  LMMIOFFSET.
- lmmi_wdata  out  DATA_W  LMMIWDATA.
- lmmi_ready  in  1  LMMIREADY.
- lmmi_rdata  in  DATA_W  LMMIRDATA.
- lmmi_rdata_valid  in  1  LMMIRDATAVALID.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, timeout counter 0, captured registers 0. Asserting rst mid-transaction aborts immediately (lmmi_request drops asynchronously) and no response is issued.
- cmd_ready = 1 only in IDLE. The command fields are captured at acceptance; later changes to the cmd_* inputs have no effect on the transaction.
- LMMI transfer rule: lmmi_request, lmmi_wr_rdn, lmmi_offset and lmmi_wdata are registered and held stable until lmmi_ready is sampled 1 while lmmi_request = 1. lmmi_request deasserts on the following cycle. A write completes at that cycle. A read is accepted at that cycle, and its data arrives on the first later cycle with lmmi_rdata_valid = 1, which is captured.
- lmmi_rdata_valid arriving outside WAIT_RD is ignored.
- FSM states: IDLE, REQ_RD, WAIT_RD, REQ_WR, RESP.
  - IDLE -> REQ_WR on a write; -> REQ_RD on a read or RMW; -> RESP with err = 1 on a reserved op (no LMMI activity).
  - REQ_RD -> WAIT_RD on lmmi_ready.
  - WAIT_RD -> REQ_WR (RMW) or RESP (read) on lmmi_rdata_valid. On the RMW path, wdata = (rdata & ~mask) | (wdata & mask), computed from the captured read data.
  - REQ_WR -> RESP on lmmi_ready.
  - RESP: rsp_valid = 1 for exactly one cycle, then IDLE.
- Timeout: the counter clears on entry to each of REQ_RD, WAIT_RD and REQ_WR and increments each cycle spent there. When it reaches TIMEOUT, lmmi_request drops, the FSM goes to RESP with rsp_err = 1, and rsp_rdata = 0.
- Latency with the responder answering immediately (lmmi_ready high in the first request cycle):
  - Write: accept at cycle 0; rsp_valid at cycle 3.
  - Read: add the rdata_valid delay.
  - RMW = read + write.
- Command-to-command: no back-to-back acceptance; at least one IDLE cycle after RESP.
- rsp_rdata holds its value until the next response.
- busy = 1 from the cycle after acceptance through RESP.

Decomposition:
- Package pll_lmmi_pkg holds:
  - op encodings: OP_WR, OP_RD, OP_RMW;
  - the FSM state enum;
  - named PLL register offset constants used by the controller (e.g. DIVA register offset).
- One sub-module, lmmi_timeout_ctr: clear/enable inputs, expired output, TIMEOUT parameter. Everything else is in the top FSM.

Test Plan:
- Write offset 0x12, data 0xA5; responder raises ready 2 cycles after request -> one LMMI write with wr_rdn = 1, offset 0x12, wdata 0xA5; rsp_valid once with err = 0; request held exactly 3 cycles.
- Read offset 0x05; responder returns rdata 0x3C with rdata_valid 4 cycles after ready -> rsp_rdata = 0x3C, err = 0, and no write issued.
- RMW offset 0x20, mask 0x0F, wdata 0x07; register holds 0xB9 -> read, then write of 0xB7; rsp_rdata = 0xB9.
- Responder never asserts ready, TIMEOUT = 16 -> request drops after 16 request cycles; rsp_err = 1, rsp_rdata = 0; next command is accepted normally.
- rst asserted while in WAIT_RD -> lmmi_request, busy and rsp_valid are 0 immediately; a late rdata_valid after reset produces no response.
- Reserved op 11 -> no LMMI activity, rsp_err = 1 one cycle after the response state is entered; cmd_ready is low while busy, and cmd_valid held high through the transaction is not accepted twice.
